// File: rtl/cc_step_counter.sv
// Step-count controller: latches a target on start, gates prescaler ticks to the
// motor driver, counts them, and ends the move on the external comparator's equal flag.
module cc_step_counter #(
  parameter int NUMBER_DATAWIDTH = 8
) (
  input  logic                        CC_STEPCOUNT_CLOCK_50,
  input  logic                        CC_STEPCOUNT_RESET_InLow,
  input  logic                        CC_STEPCOUNT_start_InHigh,
  input  logic                        CC_STEPCOUNT_abort_InHigh,
  input  logic                        CC_STEPCOUNT_tick_InHigh,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_STEPCOUNT_target_InBUS,
  input  logic                        CC_STEPCOUNT_equal_InLow,
  output logic [NUMBER_DATAWIDTH-1:0] CC_STEPCOUNT_count_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] CC_STEPCOUNT_target_OutBUS,
  output logic                        CC_STEPCOUNT_step_OutHigh,
  output logic                        CC_STEPCOUNT_busy_OutHigh,
  output logic                        CC_STEPCOUNT_done_OutHigh
);

  // state | meaning
  // IDLE  | waiting for start; count and target held
  // RUN   | gating ticks to the driver until the comparator reports equal
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUMBER_DATAWIDTH-1:0] ONE = {{(NUMBER_DATAWIDTH-1){1'b0}}, 1'b1};

  state_t                      state, state_nxt;
  logic [NUMBER_DATAWIDTH-1:0] count, count_nxt;
  logic [NUMBER_DATAWIDTH-1:0] target, target_nxt;
  logic                        step;

  always_ff @(posedge CC_STEPCOUNT_CLOCK_50 or negedge CC_STEPCOUNT_RESET_InLow) begin
    if (!CC_STEPCOUNT_RESET_InLow) begin
      state  <= IDLE;
      count  <= '0;
      target <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      target <= target_nxt;
    end
  end

  // equal_InLow comes straight from the comparator; the stop decision uses it unregistered
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    target_nxt = target;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (CC_STEPCOUNT_start_InHigh && !CC_STEPCOUNT_abort_InHigh) begin
          target_nxt = CC_STEPCOUNT_target_InBUS;
          count_nxt  = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        step = CC_STEPCOUNT_tick_InHigh & CC_STEPCOUNT_equal_InLow & ~CC_STEPCOUNT_abort_InHigh;
        if (CC_STEPCOUNT_abort_InHigh) begin
          state_nxt = IDLE;
        end else if (!CC_STEPCOUNT_equal_InLow) begin
          state_nxt = DONE;
        end else if (step) begin
          count_nxt = count + ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign CC_STEPCOUNT_count_OutBUS  = count;
  assign CC_STEPCOUNT_target_OutBUS = target;
  assign CC_STEPCOUNT_step_OutHigh  = step;
  assign CC_STEPCOUNT_busy_OutHigh  = (state == RUN);
  assign CC_STEPCOUNT_done_OutHigh  = (state == DONE);

endmodule

// File: tb/tb_cc_step_counter.sv
// Bench for cc_step_counter: models the CC_EQUAL comparator, scoreboards completed moves.
module tb_cc_step_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       tick;
  logic [7:0] tgt_in;
  logic       eq_n;
  logic [7:0] count_o;
  logic [7:0] target_o;
  logic       step;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int step_cnt = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  cc_step_counter #(.NUMBER_DATAWIDTH(8)) dut (
    .CC_STEPCOUNT_CLOCK_50     (clk),
    .CC_STEPCOUNT_RESET_InLow  (rst_n),
    .CC_STEPCOUNT_start_InHigh (start),
    .CC_STEPCOUNT_abort_InHigh (abort),
    .CC_STEPCOUNT_tick_InHigh  (tick),
    .CC_STEPCOUNT_target_InBUS (tgt_in),
    .CC_STEPCOUNT_equal_InLow  (eq_n),
    .CC_STEPCOUNT_count_OutBUS (count_o),
    .CC_STEPCOUNT_target_OutBUS(target_o),
    .CC_STEPCOUNT_step_OutHigh (step),
    .CC_STEPCOUNT_busy_OutHigh (busy),
    .CC_STEPCOUNT_done_OutHigh (done)
  );

  // downstream CC_EQUAL comparator
  assign eq_n = (count_o == target_o) ? 1'b0 : 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (step === 1'b1) step_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        obs_q.push_back(count_o);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] t);
    tgt_in = t;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    int s0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0; tgt_in = 8'd0;
    #1;
    total++; if (count_o !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
    total++; if (target_o !== 8'd0) begin bad++; $display("FAIL reset_target got=%0d want=0", target_o); end
    total++; if ({busy, done, step} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, step}); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    // reset mid-move with count=5
    launch(8'd9);
    tick = 1'b1;
    for (int i = 0; i < 20 && count_o != 8'd5; i++) cyc();
    total++; if (count_o !== 8'd5) begin bad++; $display("FAIL midrun_count got=%0d want=5", count_o); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count_o !== 8'd0) begin bad++; $display("FAIL async_count got=%0d want=0", count_o); end
    total++; if (target_o !== 8'd0) begin bad++; $display("FAIL async_target got=%0d want=0", target_o); end
    total++; if ({busy, done, step} !== 3'b000) begin bad++; $display("FAIL async_flags got=%b want=000", {busy, done, step}); end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = step_cnt;
    for (int i = 0; i < 10; i++) cyc();
    total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL post_reset_steps got=%0d want=0", step_cnt - s0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
    tick = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_target3();
    int s0, d0, c3, dn;
    logic [7:0] prev, e, o;
    exp_q.delete(); obs_q.delete();
    s0 = step_cnt; d0 = done_cnt; c3 = -1; dn = -1;
    launch(8'd3);
    exp_q.push_back(8'd3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t3_busy got=%b want=1", busy); end
    total++; if (target_o !== 8'd3) begin bad++; $display("FAIL t3_target got=%0d want=3", target_o); end
    total++; if (count_o !== 8'd0) begin bad++; $display("FAIL t3_count0 got=%0d want=0", count_o); end
    prev = count_o;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 4 == 3);
      cyc();
      if (count_o != prev) begin
        total++; if (count_o !== prev + 8'd1) begin bad++; $display("FAIL t3_seq got=%0d want=%0d", count_o, prev + 8'd1); end
        prev = count_o;
      end
      if (count_o == 8'd3 && c3 < 0) c3 = i;
      if (done === 1'b1) begin
        if (dn < 0) dn = i;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_busy_in_done got=%b want=0", busy); end
      end
    end
    tick = 1'b0;
    total++; if (step_cnt - s0 != 3) begin bad++; $display("FAIL t3_steps got=%0d want=3", step_cnt - s0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL t3_dones got=%0d want=1", done_cnt - d0); end
    total++; if (c3 < 0 || dn != c3 + 1) begin bad++; $display("FAIL t3_latency got=%0d want=%0d", dn, c3 + 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_busy_end got=%b want=0", busy); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t3_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++; if (o !== e) begin bad++; $display("FAIL t3_sb got=%0d want=%0d", o, e); end
      end
    end
  endtask

  task automatic test_target0();
    int s0;
    logic [7:0] e, o;
    exp_q.delete(); obs_q.delete();
    s0 = step_cnt;
    tick = 1'b1;
    launch(8'd0);
    exp_q.push_back(8'd0);
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL t0_cyc1 got=%b want=10", {busy, done}); end
    cyc();
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL t0_cyc2 got=%b want=01", {busy, done}); end
    cyc();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL t0_cyc3 got=%b want=00", {busy, done}); end
    tick = 1'b0;
    total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL t0_steps got=%0d want=0", step_cnt - s0); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t0_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL t0_sb got=%0d want=%0d", o, e); end
    end
  endtask

  task automatic test_abort();
    int s0, d0;
    logic [7:0] e, o;
    exp_q.delete(); obs_q.delete();
    d0 = done_cnt;
    launch(8'd10);
    tick = 1'b1;
    for (int i = 0; i < 20 && count_o != 8'd4; i++) cyc();
    total++; if (count_o !== 8'd4) begin bad++; $display("FAIL ab_reach got=%0d want=4", count_o); end
    abort = 1'b1;
    #1;
    total++; if (step !== 1'b0) begin bad++; $display("FAIL ab_step got=%b want=0", step); end
    cyc();
    abort = 1'b0;
    tick = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b want=0", busy); end
    total++; if (count_o !== 8'd4) begin bad++; $display("FAIL ab_count got=%0d want=4", count_o); end
    total++; if (target_o !== 8'd10) begin bad++; $display("FAIL ab_target got=%0d want=10", target_o); end
    for (int i = 0; i < 5; i++) cyc();
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL ab_done got=%0d want=0", done_cnt - d0); end
    // restart after abort, with a start+abort collision first: abort wins
    tgt_in = 8'd2; start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_collide got=%b want=0", busy); end
    s0 = step_cnt;
    launch(8'd2);
    exp_q.push_back(8'd2);
    total++; if (count_o !== 8'd0) begin bad++; $display("FAIL ab_restart_count got=%0d want=0", count_o); end
    tick = 1'b1;
    for (int i = 0; i < 20 && done !== 1'b1; i++) cyc();
    tick = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ab_restart_done got=%b want=1", done); end
    cyc();
    total++; if (step_cnt - s0 != 2) begin bad++; $display("FAIL ab_restart_steps got=%0d want=2", step_cnt - s0); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ab_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL ab_sb got=%0d want=%0d", o, e); end
    end
  endtask

  task automatic test_full_range();
    int s0, d0, wraps;
    logic [7:0] prev, e, o;
    exp_q.delete(); obs_q.delete();
    s0 = step_cnt; d0 = done_cnt; wraps = 0;
    launch(8'd255);
    exp_q.push_back(8'd255);
    prev = count_o;
    tick = 1'b1;
    for (int i = 0; i < 300 && done !== 1'b1; i++) begin
      cyc();
      if (count_o < prev) wraps++;
      prev = count_o;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b want=1", done); end
    total++; if (wraps != 0) begin bad++; $display("FAIL full_wraps got=%0d want=0", wraps); end
    total++; if (count_o !== 8'd255) begin bad++; $display("FAIL full_count got=%0d want=255", count_o); end
    for (int i = 0; i < 3; i++) cyc();
    tick = 1'b0;
    total++; if (step_cnt - s0 != 255) begin bad++; $display("FAIL full_steps got=%0d want=255", step_cnt - s0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL full_dones got=%0d want=1", done_cnt - d0); end
    total++; if (count_o !== 8'd255) begin bad++; $display("FAIL full_hold got=%0d want=255", count_o); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL full_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL full_sb got=%0d want=%0d", o, e); end
    end
  endtask

  task automatic test_restart_ignored();
    int s0;
    logic [7:0] e, o;
    exp_q.delete(); obs_q.delete();
    s0 = step_cnt;
    launch(8'd5);
    exp_q.push_back(8'd5);
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    tick = 1'b1; cyc();
    total++; if (count_o !== 8'd2) begin bad++; $display("FAIL rs_count2 got=%0d want=2", count_o); end
    tgt_in = 8'd7; start = 1'b1; tick = 1'b1;
    cyc();
    start = 1'b0; tick = 1'b0;
    total++; if (target_o !== 8'd5) begin bad++; $display("FAIL rs_target got=%0d want=5", target_o); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs_busy got=%b want=1", busy); end
    total++; if (count_o !== 8'd3) begin bad++; $display("FAIL rs_count3 got=%0d want=3", count_o); end
    for (int i = 0; i < 40 && done !== 1'b1; i++) begin
      tick = (i % 2 == 0);
      cyc();
    end
    tick = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rs_done got=%b want=1", done); end
    total++; if (count_o !== 8'd5) begin bad++; $display("FAIL rs_final got=%0d want=5", count_o); end
    cyc();
    total++; if (step_cnt - s0 != 5) begin bad++; $display("FAIL rs_steps got=%0d want=5", step_cnt - s0); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rs_sb_size got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL rs_sb got=%0d want=%0d", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_target3();
    test_target0();
    test_abort();
    test_full_range();
    test_restart_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
